char_num_writer: RTL and testbench
==================================

Name: char_num_writer

Overview:
- Writer side of the character RAM write port (ram_we / ram_addr / ram_data) consumed by the character/map display top.
- On a request, converts a 16-bit unsigned value to right-aligned decimal ASCII.
- Writes the result into the 40x15 character grid at a given row/column, one cell per clock.
- Sits between the sensor/status logic (speed, distance, etc.) and the display top.

Parameters:
- COLS, 40, character columns per row; address = row*COLS + col.
- ROWS, 15, character rows; a request with row >= ROWS is rejected.
- BLANK_CHAR, 7'h20, pad character for leading zeros when zero_pad=0.
- OVF_CHAR, 7'h2A, fill character when the value needs more digits than the field width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  request strobe; sampled only in IDLE
- value  input  16  unsigned number to display
- row  input  4  target row, 0..ROWS-1
- col  input  6  column of leftmost field cell, 0..COLS-1
- width  input  3  field width in digits; 0 treated as 1, >5 treated as 5
- zero_pad  input  1  1: leading zeros shown as '0'; 0: shown as BLANK_CHAR
- ram_we  output  1  character RAM write enable, one cycle per cell
- ram_addr  output  10  character RAM address
- ram_data  output  7  ASCII code
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; 1 = request rejected (row out of range)

Behaviour:
- Reset (rst=0, asynchronous) forces state IDLE and all outputs to 0: ram_we, ram_addr, ram_data, busy, done, err. Reset mid-operation abandons the field and leaves any partial writes in RAM.
- All outputs are registered.
- State machine: IDLE -> CONV -> WRITE -> FIN -> IDLE.
- IDLE:
  - When start=1, latch value, row, col, the clamped width W and zero_pad; go to CONV; busy=1 from the next cycle.
  - If row >= ROWS, go straight to FIN with err=1 and perform no writes.
  - start while busy is ignored, with no queueing.
- CONV: double-dabble over exactly 16 cycles, producing 5 BCD digits d4..d0 (d4 most significant).
- Digit-count rule:
  - n = index of the highest nonzero digit + 1; value 0 gives n = 1.
  - Overflow when n > W.
- Base address = row*COLS + col, computed at 10 bits. The maximum, 14*40+39 = 599, never wraps.
- WRITE: W cycles, i = 0..W-1, leftmost cell first.
  - ram_addr = base + i.
  - ram_data:
    - overflow: OVF_CHAR.
    - digit position k = W-1-i with k >= n: '0' if zero_pad=1, else BLANK_CHAR.
    - otherwise: 7'h30 + d_k.
  - ram_we=1 only when col+i <= COLS-1. Cells past the row end are clipped: the cycle is still spent, ram_we=0, and nothing spills into the next row.
  - ram_addr and ram_data hold their last values when ram_we=0.
- FIN: done=1 and busy=0 for one cycle, err as determined; then IDLE. A start during FIN is ignored.
- Latency: with start accepted at cycle 0:
  - CONV occupies cycles 1..16.
  - Writes occupy cycles 17..16+W.
  - done occurs at cycle 17+W.
  - Rejected request: done and err at cycle 1.
- Back-to-back: a new start is accepted in the cycle after done.

Test Plan:
- value=1234, row=2, col=10, W=5, zero_pad=0 -> writes at addr 90..94 of ' ','1','2','3','4' (20,31,32,33,34h), cycles 17..21; done at cycle 22.
- value=7, W=3, zero_pad=1, row=0, col=0 -> addr 0,1,2 = '0','0','7'; value=0, zero_pad=0, W=2 -> ' ','0'.
- value=65535, W=4 -> four writes of 2Ah; W=0 with value=5 -> one write of '5'; W=7 treated as 5.
- row=14, col=38, W=4, value=42 -> ram_we only at addr 598,599 with ' ',' '; cycles 3 and 4 of WRITE have ram_we=0; done after 4 write cycles.
- row=15 -> no ram_we; done=1 and err=1 at cycle 1; a start pulse during a busy conversion is ignored and causes no extra done.
- Drive rst low during WRITE -> all outputs 0 immediately; after release, a new request completes normally.

Source files
------------

// File: rtl/char_num_writer.sv
// char_num_writer
//   Renders a 16-bit unsigned value as right-aligned decimal ASCII into the
//   COLS x ROWS character RAM, one cell per clock.
//   Flow: IDLE -> CONV (16-cycle double-dabble) -> WRITE (W cells) -> FIN.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               request strobe, only looked at in IDLE
//   value/row/col       number and top-left target cell of the field
//   width               field width in digits (0 -> 1, >5 -> 5)
//   zero_pad            leading zeros as '0' (1) or BLANK_CHAR (0)
//   ram_we/addr/data    character RAM write port (registered)
//   busy, done, err     status; err qualifies done (row out of range)
module char_num_writer #(
  parameter int         COLS       = 40,
  parameter int         ROWS       = 15,
  parameter logic [6:0] BLANK_CHAR = 7'h20,
  parameter logic [6:0] OVF_CHAR   = 7'h2A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  input  logic [3:0]  row,
  input  logic [5:0]  col,
  input  logic [2:0]  width,
  input  logic        zero_pad,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [6:0]  ram_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CONV, WRITE, FIN} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [15:0] sh, sh_n;
  logic [19:0] bcd, bcd_n, step;
  logic [9:0]  base_q, base_n;
  logic [5:0]  col_q, col_n;
  logic [2:0]  w_q, w_n;
  logic        zp_q, zp_n;
  logic        we_n, busy_n, done_n, err_n;
  logic [9:0]  addr_n;
  logic [6:0]  data_n;
  logic        emit;
  logic [2:0]  ei;
  logic [19:0] ed;

  // One double-dabble iteration: add 3 to any digit >= 5, then shift in a bit.
  function automatic logic [19:0] dd_step(input logic [19:0] b, input logic in_bit);
    logic [19:0] a;
    a = b;
    for (int j = 0; j < 5; j++)
      if (a[j*4 +: 4] >= 4'd5) a[j*4 +: 4] = a[j*4 +: 4] + 4'd3;
    return {a[18:0], in_bit};
  endfunction

  // Character for field cell i (0 = leftmost) of a w-digit field.
  function automatic logic [6:0] cell_char(input logic [19:0] d, input logic [2:0] i,
                                           input logic [2:0] w, input logic zp);
    int n, k;
    n = 1;
    for (int j = 0; j < 5; j++)
      if (d[j*4 +: 4] != 4'd0) n = j + 1;
    k = int'(w) - 1 - int'(i);
    if (n > int'(w))  return OVF_CHAR;
    else if (k >= n)  return zp ? 7'h30 : BLANK_CHAR;
    else              return 7'h30 + {3'b000, d[k*4 +: 4]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      bcd      <= '0;
      base_q   <= '0;
      col_q    <= '0;
      w_q      <= '0;
      zp_q     <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      bcd      <= bcd_n;
      base_q   <= base_n;
      col_q    <= col_n;
      w_q      <= w_n;
      zp_q     <= zp_n;
      ram_we   <= we_n;
      ram_addr <= addr_n;
      ram_data <= data_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    bcd_n   = bcd;
    base_n  = base_q;
    col_n   = col_q;
    w_n     = w_q;
    zp_n    = zp_q;
    we_n    = 1'b0;
    addr_n  = ram_addr;
    data_n  = ram_data;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    emit    = 1'b0;
    ei      = '0;
    ed      = bcd;
    step    = dd_step(bcd, sh[15]);

    case (state)
      IDLE: if (start) begin
        w_n    = (width == 3'd0) ? 3'd1 : (width > 3'd5) ? 3'd5 : width;
        zp_n   = zero_pad;
        col_n  = col;
        sh_n   = value;
        bcd_n  = '0;
        cnt_n  = '0;
        base_n = 10'(row) * 10'(COLS) + 10'(col);
        if (int'(row) >= ROWS) begin
          state_n = FIN;
          done_n  = 1'b1;
          err_n   = 1'b1;
          busy_n  = 1'b0;
        end else begin
          state_n = CONV;
          busy_n  = 1'b1;
        end
      end
      CONV: begin
        sh_n  = {sh[14:0], 1'b0};
        bcd_n = step;
        cnt_n = cnt + 4'd1;
        // The last conversion step feeds cell 0 directly so the first write
        // lands in the cycle right after CONV.
        if (cnt == 4'd15) begin
          state_n = WRITE;
          idx_n   = 3'd1;
          emit    = 1'b1;
          ei      = 3'd0;
          ed      = step;
        end
      end
      WRITE: begin
        if (idx == w_q) begin
          state_n = FIN;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          emit  = 1'b1;
          ei    = idx;
          idx_n = idx + 3'd1;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Cells beyond the row end still consume a cycle but are not written.
    if (emit && ({1'b0, col_q} + {4'b0000, ei}) <= 7'(COLS - 1)) begin
      we_n   = 1'b1;
      addr_n = base_q + {7'b0, ei};
      data_n = cell_char(ed, ei, w_q, zp_q);
    end
  end

endmodule

// File: tb/tb_char_num_writer.sv
// Bench for char_num_writer: a decimal-arithmetic reference model predicts
// every output cycle by cycle; directed requests pin the model with literals.
module tb_char_num_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  row = '0;
  logic [5:0]  col = '0;
  logic [2:0]  width = '0;
  logic        zero_pad = 1'b0;
  logic        ram_we, busy, done, err;
  logic [9:0]  ram_addr;
  logic [6:0]  ram_data;

  int total = 0;
  int bad   = 0;

  char_num_writer dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .row(row), .col(col),
    .width(width), .zero_pad(zero_pad), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       we;
    logic [9:0] addr;
    logic [6:0] data;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t cur = '0;
  exp_t plan[$];

  task automatic build(input int v, input int r, input int c, input int wr, input int zp,
                       input logic [9:0] ha0, input logic [6:0] hd0);
    int W, n, t, k, p, ch;
    logic [9:0] ha;
    logic [6:0] hd;
    exp_t e;
    ha = ha0;
    hd = hd0;
    W = (wr == 0) ? 1 : (wr > 5) ? 5 : wr;
    if (r >= 15) begin
      e = '{we:1'b0, addr:ha, data:hd, busy:1'b0, done:1'b1, err:1'b1};
      plan.push_back(e);
      return;
    end
    for (int q = 0; q < 16; q++) begin
      e = '{we:1'b0, addr:ha, data:hd, busy:1'b1, done:1'b0, err:1'b0};
      plan.push_back(e);
    end
    n = 1;
    t = v;
    while (t >= 10) begin t = t / 10; n++; end
    for (int i = 0; i < W; i++) begin
      k = W - 1 - i;
      p = 1;
      for (int q = 0; q < k; q++) p = p * 10;
      if (n > W)       ch = 'h2A;
      else if (k >= n) ch = zp ? 'h30 : 'h20;
      else             ch = 'h30 + (v / p) % 10;
      if (c + i <= 39) begin
        ha = 10'(r * 40 + c + i);
        hd = 7'(ch);
        e = '{we:1'b1, addr:ha, data:hd, busy:1'b1, done:1'b0, err:1'b0};
      end else begin
        e = '{we:1'b0, addr:ha, data:hd, busy:1'b1, done:1'b0, err:1'b0};
      end
      plan.push_back(e);
    end
    e = '{we:1'b0, addr:ha, data:hd, busy:1'b0, done:1'b1, err:1'b0};
    plan.push_back(e);
  endtask

  // cur = outputs expected during the cycle following each rising edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      plan.delete();
      cur = '0;
    end else begin
      if (plan.size() == 0 && !cur.done && start)
        build(int'(value), int'(row), int'(col), int'(width), int'(zero_pad), cur.addr, cur.data);
      if (plan.size() > 0) cur = plan.pop_front();
      else cur = '{we:1'b0, addr:cur.addr, data:cur.data, busy:1'b0, done:1'b0, err:1'b0};
    end
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [6:0] data;
  } wr_t;

  wr_t wlog[$];
  int  dcyc;
  logic derr;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic do_req(input logic [15:0] v, input logic [3:0] r, input logic [5:0] c,
                        input logic [2:0] w, input logic zp, input int rst_at, input int pulse_at);
    wlog.delete();
    dcyc = 0;
    derr = 1'b0;
    @(negedge clk);
    value = v; row = r; col = c; width = w; zero_pad = zp; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == pulse_at) begin
        start = 1'b1;
        value = 16'd1;
        row = 4'd0;
      end
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1 chk("rst_mid_outputs", {10'b0, ram_we, ram_addr, ram_data, busy, done, err}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        return;
      end
      if (ram_we) wlog.push_back('{k, ram_addr, ram_data});
      if (done) begin
        dcyc = k;
        derr = err;
        break;
      end
    end
    if (start) begin
      @(negedge clk);
      start = 1'b0;
    end
    if (dcyc == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_w(input string nm, input int nexp, input int a0, input logic [34:0] dv);
    chk({nm, "_nwrites"}, wlog.size(), nexp);
    for (int i = 0; i < nexp && i < wlog.size(); i++) begin
      chk({nm, "_addr"}, wlog[i].addr, a0 + i);
      chk({nm, "_data"}, wlog[i].data, dv[34 - 7*i -: 7]);
      chk({nm, "_cyc"}, wlog[i].cyc, 17 + i);
    end
  endtask

  // ---------------- main sequence + per-cycle compare ----------------
  initial begin
    int extra;
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          total++;
          if ({ram_we, ram_addr, ram_data, busy, done, err} !== cur) begin
            bad++;
            $display("FAIL model_cmp t=%0t got we=%0b a=%0d d=%0h b=%0b dn=%0b e=%0b exp we=%0b a=%0d d=%0h b=%0b dn=%0b e=%0b",
                     $time, ram_we, ram_addr, ram_data, busy, done, err,
                     cur.we, cur.addr, cur.data, cur.busy, cur.done, cur.err);
          end
        end
      end
    join_none

    #1 rst = 1'b0;
    #2 chk("reset_outputs", {10'b0, ram_we, ram_addr, ram_data, busy, done, err}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    do_req(16'd1234, 4'd2, 6'd10, 3'd5, 1'b0, 0, 0);
    chk("r1_done", dcyc, 22); chk("r1_err", derr, 0);
    chk_w("r1", 5, 90, {7'h20, 7'h31, 7'h32, 7'h33, 7'h34});

    do_req(16'd7, 4'd0, 6'd0, 3'd3, 1'b1, 0, 0);
    chk("r2_done", dcyc, 20);
    chk_w("r2", 3, 0, {7'h30, 7'h30, 7'h37, 14'd0});

    do_req(16'd0, 4'd0, 6'd5, 3'd2, 1'b0, 0, 0);
    chk("r3_done", dcyc, 19);
    chk_w("r3", 2, 5, {7'h20, 7'h30, 21'd0});

    do_req(16'd65535, 4'd1, 6'd0, 3'd4, 1'b0, 0, 0);
    chk("r4_done", dcyc, 21);
    chk_w("r4", 4, 40, {7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'd0});

    do_req(16'd5, 4'd0, 6'd0, 3'd0, 1'b0, 0, 0);
    chk("r5_done", dcyc, 18);
    chk_w("r5", 1, 0, {7'h35, 28'd0});

    do_req(16'd123, 4'd3, 6'd0, 3'd7, 1'b1, 0, 0);
    chk("r6_done", dcyc, 22);
    chk_w("r6", 5, 120, {7'h30, 7'h30, 7'h31, 7'h32, 7'h33});

    do_req(16'd42, 4'd14, 6'd38, 3'd4, 1'b0, 0, 0);
    chk("r7_done", dcyc, 21);
    chk_w("r7", 2, 598, {7'h20, 7'h20, 21'd0});

    do_req(16'd9, 4'd15, 6'd0, 3'd3, 1'b0, 0, 0);
    chk("r8_done", dcyc, 1); chk("r8_err", derr, 1); chk("r8_nwrites", wlog.size(), 0);

    // start pulses while busy and during the done cycle must be ignored
    do_req(16'd1234, 4'd2, 6'd10, 3'd5, 1'b0, 0, 5);
    chk("r9_done", dcyc, 22);
    chk_w("r9", 5, 90, {7'h20, 7'h31, 7'h32, 7'h33, 7'h34});
    do_req(16'd88, 4'd0, 6'd0, 3'd2, 1'b0, 0, 19);
    chk("r10_done", dcyc, 19);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("no_extra_activity", extra, 0);

    // reset in the middle of WRITE, then a clean request
    do_req(16'd999, 4'd0, 6'd0, 3'd5, 1'b0, 18, 0);
    do_req(16'd56, 4'd5, 6'd1, 3'd2, 1'b0, 0, 0);
    chk("r11_done", dcyc, 19);
    chk_w("r11", 2, 201, {7'h35, 7'h36, 21'd0});

    // randomized traffic, checked purely by the model
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 5) == 0);
      value    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 120)) : 16'($urandom);
      row      = 4'($urandom_range(0, 15));
      col      = 6'($urandom_range(0, 39));
      width    = 3'($urandom_range(0, 7));
      zero_pad = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
